// File: rtl/serial_sub.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_sub : bit-serial unsigned subtractor (X-Y-Bin), optional |X-Y-Bin|
// rev 1.0
// ---------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] NEG   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             b_q, b_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             bit_x, bit_y, bit_d, b_next;
  logic [WIDTH-1:0] raw;

  always_comb begin
    bit_x  = x_q[0];
    bit_y  = y_q[0];
    bit_d  = bit_x ^ bit_y ^ b_q;
    b_next = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & b_q);
    // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
    raw    = {bit_d, sr_q[WIDTH-1:1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sr_d    = sr_q;
    b_d     = b_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = X;
          y_d     = Y;
          b_d     = Bin;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        x_d   = x_q >> 1;
        y_d   = y_q >> 1;
        b_d   = b_next;
        sr_d  = raw;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (mode_q && b_next) begin
            state_d = NEG;
          end else begin
            state_d = IDLE;
            diff_d  = raw;
            bout_d  = b_next;
            done_d  = 1'b1;
          end
        end
      end
      NEG: begin
        // A raw of zero negates to zero: the 2^WIDTH magnitude wraps.
        diff_d  = ~sr_q + WIDTH'(1);
        bout_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sr_q    <= '0;
      b_q     <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sr_q    <= sr_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// tb_serial_sub : directed and random checks of serial_sub at WIDTH 2, 8, 64.
module tb_serial_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start2 = 1'b0, start8 = 1'b0, start64 = 1'b0;
  logic [63:0] x_in = '0, y_in = '0;
  logic        bin_in = 1'b0, mode_in = 1'b0;

  logic        busy2, done2, bout2;
  logic [1:0]  diff2;
  logic        busy8, done8, bout8;
  logic [7:0]  diff8;
  logic        busy64, done64, bout64;
  logic [63:0] diff64;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .X(x_in[1:0]), .Y(y_in[1:0]),
    .Bin(bin_in), .mode(mode_in), .busy(busy2), .done(done2), .Diff(diff2), .Bout(bout2)
  );
  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .X(x_in[7:0]), .Y(y_in[7:0]),
    .Bin(bin_in), .mode(mode_in), .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
  );
  serial_sub #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .X(x_in), .Y(y_in),
    .Bin(bin_in), .mode(mode_in), .busy(busy64), .done(done64), .Diff(diff64), .Bout(bout64)
  );

  function automatic logic get_done(input int w);
    case (w)
      2:       return done2;
      8:       return done8;
      default: return done64;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      2:       return busy2;
      8:       return busy8;
      default: return busy64;
    endcase
  endfunction

  function automatic logic get_bout(input int w);
    case (w)
      2:       return bout2;
      8:       return bout8;
      default: return bout64;
    endcase
  endfunction

  function automatic logic [63:0] get_diff(input int w);
    case (w)
      2:       return {62'd0, diff2};
      8:       return {56'd0, diff8};
      default: return diff64;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      2:       start2 = v;
      8:       start8 = v;
      default: start64 = v;
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge; leaves in the done cycle.
  task automatic run_op(input int w, input logic [63:0] x, input logic [63:0] y,
                        input logic b, input logic m, output logic [63:0] diff,
                        output logic bout, output int lat, output int busy_bad);
    x_in = x; y_in = y; bin_in = b; mode_in = m;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    lat = -1; busy_bad = 0; diff = '0; bout = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (get_done(w)) begin
        lat = i;
        if (get_busy(w)) busy_bad++;
        diff = get_diff(w);
        bout = get_bout(w);
        break;
      end
      if (!get_busy(w)) busy_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; x_in = 64'h5A; y_in = 64'h3C;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8); else n_pass++;
    n_total++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b want 0", done8); else n_pass++;
    n_total++; if (diff8 !== 8'h00) $display("FAIL reset_diff: got %h want 00", diff8); else n_pass++;
    n_total++; if (bout8 !== 1'b0) $display("FAIL reset_bout: got %b want 0", bout8); else n_pass++;
    start8 = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sub();
    logic [63:0] d; logic bo; int lat, bb;
    run_op(8, 64'h5A, 64'h3C, 1'b0, 1'b0, d, bo, lat, bb);
    n_total++; if (d !== 64'h1E) $display("FAIL sub1_diff: got %h want 1e", d); else n_pass++;
    n_total++; if (bo !== 1'b0) $display("FAIL sub1_bout: got %b want 0", bo); else n_pass++;
    n_total++; if (lat != 9) $display("FAIL sub1_latency: got %0d want 9", lat); else n_pass++;
    n_total++; if (bb != 0) $display("FAIL sub1_busy: %0d bad cycles want 0", bb); else n_pass++;
    @(posedge clk); #1;
    run_op(8, 64'h00, 64'h01, 1'b0, 1'b0, d, bo, lat, bb);
    n_total++; if (d !== 64'hFF) $display("FAIL sub2_diff: got %h want ff", d); else n_pass++;
    n_total++; if (bo !== 1'b1) $display("FAIL sub2_bout: got %b want 1", bo); else n_pass++;
    n_total++; if (lat != 9) $display("FAIL sub2_latency: got %0d want 9", lat); else n_pass++;
    n_total++; if (bb != 0) $display("FAIL sub2_busy: %0d bad cycles want 0", bb); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abs_mode();
    logic [63:0] d; logic bo; int lat, bb;
    run_op(8, 64'h10, 64'h30, 1'b0, 1'b1, d, bo, lat, bb);
    n_total++; if (d !== 64'h20) $display("FAIL abs1_diff: got %h want 20", d); else n_pass++;
    n_total++; if (bo !== 1'b1) $display("FAIL abs1_bout: got %b want 1", bo); else n_pass++;
    n_total++; if (lat != 10) $display("FAIL abs1_latency: got %0d want 10", lat); else n_pass++;
    n_total++; if (bb != 0) $display("FAIL abs1_busy: %0d bad cycles want 0", bb); else n_pass++;
    @(posedge clk); #1;
    run_op(8, 64'h00, 64'hFF, 1'b1, 1'b1, d, bo, lat, bb);
    n_total++; if (d !== 64'h00) $display("FAIL abs_wrap_diff: got %h want 00", d); else n_pass++;
    n_total++; if (bo !== 1'b1) $display("FAIL abs_wrap_bout: got %b want 1", bo); else n_pass++;
    n_total++; if (lat != 10) $display("FAIL abs_wrap_latency: got %0d want 10", lat); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int ndone = 0; int first = -1; logic [7:0] d = '0;
    x_in = 64'h5A; y_in = 64'h3C; bin_in = 1'b0; mode_in = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin x_in = 64'hFF; y_in = 64'h00; start8 = 1'b1; end
      if (i == 4) start8 = 1'b0;
      if (done8) begin ndone++; if (first < 0) begin first = i; d = diff8; end end
      @(posedge clk); #1;
    end
    n_total++; if (d !== 8'h1E) $display("FAIL ignore_diff: got %h want 1e", d); else n_pass++;
    n_total++; if (ndone != 1) $display("FAIL ignore_done_count: got %0d want 1", ndone); else n_pass++;
    n_total++; if (first != 9) $display("FAIL ignore_latency: got %0d want 9", first); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; logic bo; int lat, bb;
    run_op(8, 64'h5A, 64'h3C, 1'b0, 1'b0, d, bo, lat, bb);
    n_total++; if (d !== 64'h1E) $display("FAIL b2b_first_diff: got %h want 1e", d); else n_pass++;
    // Still in the done cycle: the next start must be accepted at its closing edge.
    run_op(8, 64'h00, 64'h01, 1'b0, 1'b0, d, bo, lat, bb);
    n_total++; if (d !== 64'hFF) $display("FAIL b2b_second_diff: got %h want ff", d); else n_pass++;
    n_total++; if (bo !== 1'b1) $display("FAIL b2b_second_bout: got %b want 1", bo); else n_pass++;
    n_total++; if (lat != 9) $display("FAIL b2b_second_latency: got %0d want 9", lat); else n_pass++;
    n_total++; if (bb != 0) $display("FAIL b2b_busy: %0d bad cycles want 0", bb); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [63:0] d; logic bo; int lat, bb; int ndone = 0;
    x_in = 64'h5A; y_in = 64'h3C; bin_in = 1'b0; mode_in = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (busy8 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy8); else n_pass++;
    n_total++; if (diff8 !== 8'h00) $display("FAIL abort_diff: got %h want 00", diff8); else n_pass++;
    n_total++; if (bout8 !== 1'b0) $display("FAIL abort_bout: got %b want 0", bout8); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(posedge clk); #1;
    end
    n_total++; if (ndone != 0) $display("FAIL abort_no_done: got %0d pulses want 0", ndone); else n_pass++;
    run_op(8, 64'h80, 64'h7F, 1'b0, 1'b0, d, bo, lat, bb);
    n_total++; if (d !== 64'h01) $display("FAIL after_abort_diff: got %h want 01", d); else n_pass++;
    n_total++; if (bo !== 1'b0) $display("FAIL after_abort_bout: got %b want 0", bo); else n_pass++;
    n_total++; if (lat != 9) $display("FAIL after_abort_latency: got %0d want 9", lat); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic check_model(input int w, input logic [63:0] x, input logic [63:0] y,
                             input logic b, input logic m);
    logic [63:0] mask, d, ed; logic bo, eb; int lat, bb, elat;
    logic [64:0] full;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = x & mask; y = y & mask;
    full = {1'b0, x} - {1'b0, y} - {64'd0, b};
    eb = full[64];
    ed = ((m && eb) ? (65'd0 - full) : full) & {1'b0, mask};
    elat = w + 1 + ((m && eb) ? 1 : 0);
    run_op(w, x, y, b, m, d, bo, lat, bb);
    n_total++;
    if (d !== ed || bo !== eb || lat != elat || bb != 0)
      $display("FAIL rand_w%0d x=%h y=%h b=%b m=%b: got diff=%h bout=%b lat=%0d busybad=%0d want diff=%h bout=%b lat=%0d busybad=0",
               w, x, y, b, m, d, bo, lat, bb, ed, eb, elat);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int k = 0; k < 4; k++)
          check_model(2, 64'(x), 64'(y), k[0], k[1]);
    check_model(64, 64'd0, '1, 1'b1, 1'b1);
    check_model(64, '1, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) begin
      check_model(8, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom));
      check_model(64, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_sub();
    test_abs_mode();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
